bot_port_master: RTL and testbench

- Hardware initiator on the KCPSM6-style port bus (port_id / out_port / in_port / read_strobe / write_strobe / interrupt / interrupt_ack).
- Replaces the firmware display-refresh loop. On each bot-update interrupt raised by the I/O interface, it acknowledges the interrupt and reads LocX, LocY, BotInfo and Sensors. It then writes their hex nibbles to the eight 7-segment digit ports.
- Sits where the CPU sits and drives the same responder. A top-level mux selects between it and the CPU.

---
 rtl/bot_port_master_pkg.sv | 51 +++++
 rtl/bot_port_master_port_xact.sv | 99 +++++++++
 rtl/bot_port_master.sv | 150 +++++++++++++++
 tb/tb_bot_port_master.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bot_port_master_pkg.sv
// bot_port_master_pkg
//   Shared definitions for the hardware port-bus initiator that refreshes the
//   eight 7-segment digits from the bot-update registers.
//   Contents: sequencer state encoding, transaction-engine phase encoding,
//   default port addresses shared with the I/O interface, transaction counts
//   and a nibble-select helper.
package bot_port_master_pkg;

  // Sequencer state encoding (3 bits)
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ACK       = 3'd1;
  localparam logic [2:0] S_RD_SETUP  = 3'd2;
  localparam logic [2:0] S_RD_STROBE = 3'd3;
  localparam logic [2:0] S_WR_SETUP  = 3'd4;
  localparam logic [2:0] S_WR_STROBE = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_ACK       = S_ACK,
    ST_RD_SETUP  = S_RD_SETUP,
    ST_RD_STROBE = S_RD_STROBE,
    ST_WR_SETUP  = S_WR_SETUP,
    ST_WR_STROBE = S_WR_STROBE,
    ST_DONE      = S_DONE
  } state_e;

  // Phases of one two-cycle bus transaction
  typedef enum logic [1:0] {
    XP_IDLE   = 2'd0,
    XP_SETUP  = 2'd1,
    XP_STROBE = 2'd2
  } xact_phase_e;

  // Default port addresses, matching the I/O interface decode
  localparam logic [7:0] PA_LOCX_DEF     = 8'h0A;
  localparam logic [7:0] PA_LOCY_DEF     = 8'h0B;
  localparam logic [7:0] PA_BOTINFO_DEF  = 8'h0C;
  localparam logic [7:0] PA_SENSORS_DEF  = 8'h0D;
  localparam logic [7:0] PA_DIG_BASE_DEF = 8'h10;

  // Transactions per refresh sequence
  localparam int RD_COUNT = 4;
  localparam int WR_COUNT = 8;

  // Picks the upper or lower hex nibble of a captured register
  function automatic logic [3:0] digitNibble(input logic [7:0] value, input logic lowHalf);
    return lowHalf ? value[3:0] : value[7:4];
  endfunction

endpackage

// File: rtl/bot_port_master_port_xact.sv
// port_xact
//   Two-cycle port-bus transaction engine. A start pulse loads the address
//   (and write data) for a setup cycle; the following cycle raises the read or
//   write strobe with the same address/data held.
//   Ports:
//     clk_i, rst_i       clock, asynchronous active-high reset
//     start_i            begin a transaction on the next cycle
//     isWrite_i          1 = write transaction, 0 = read
//     addr_i, data_i     port address and write data for the transaction
//     inPort_i           read data from the responder
//     portId_o/outPort_o registered bus address/data
//     readStrobe_o       registered read strobe (strobe cycle only)
//     writeStrobe_o      registered write strobe (strobe cycle only)
//     rdata_o            responder data as seen during a read strobe cycle
//     done_o             high during the strobe cycle; the transaction ends
//                        on the closing edge of that cycle
module port_xact
  import bot_port_master_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       isWrite_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] data_i,
  input  logic [7:0] inPort_i,
  output logic [7:0] portId_o,
  output logic [7:0] outPort_o,
  output logic       readStrobe_o,
  output logic       writeStrobe_o,
  output logic [7:0] rdata_o,
  output logic       done_o
);

  xact_phase_e phase_q, phase_d;
  logic [7:0]  portId_q, portId_d;
  logic [7:0]  outPort_q, outPort_d;
  logic        isWrite_q, isWrite_d;
  logic        readStrobe_q, readStrobe_d;
  logic        writeStrobe_q, writeStrobe_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q       <= XP_IDLE;
      portId_q      <= 8'h00;
      outPort_q     <= 8'h00;
      isWrite_q     <= 1'b0;
      readStrobe_q  <= 1'b0;
      writeStrobe_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      portId_q      <= portId_d;
      outPort_q     <= outPort_d;
      isWrite_q     <= isWrite_d;
      readStrobe_q  <= readStrobe_d;
      writeStrobe_q <= writeStrobe_d;
    end
  end

  // A start arriving during a strobe cycle chains the next transaction with
  // no gap; strobes are only ever set on entry to the strobe phase.
  always_comb begin
    phase_d       = phase_q;
    portId_d      = portId_q;
    outPort_d     = outPort_q;
    isWrite_d     = isWrite_q;
    readStrobe_d  = 1'b0;
    writeStrobe_d = 1'b0;
    if (start_i) begin
      phase_d   = XP_SETUP;
      portId_d  = addr_i;
      outPort_d = isWrite_i ? data_i : 8'h00;
      isWrite_d = isWrite_i;
    end else begin
      case (phase_q)
        XP_SETUP: begin
          phase_d       = XP_STROBE;
          readStrobe_d  = ~isWrite_q;
          writeStrobe_d = isWrite_q;
        end
        XP_STROBE: begin
          phase_d   = XP_IDLE;
          portId_d  = 8'h00;
          outPort_d = 8'h00;
        end
        default: phase_d = XP_IDLE;
      endcase
    end
  end

  assign portId_o      = portId_q;
  assign outPort_o     = outPort_q;
  assign readStrobe_o  = readStrobe_q;
  assign writeStrobe_o = writeStrobe_q;
  assign done_o        = (phase_q == XP_STROBE);
  // Only the strobe cycle of a read may deliver data
  assign rdata_o       = (phase_q == XP_STROBE && !isWrite_q) ? inPort_i : 8'h00;

endmodule

// File: rtl/bot_port_master.sv
// bot_port_master
//   Port-bus initiator that replaces the firmware display-refresh loop. On a
//   bot-update interrupt it acknowledges, reads LocX/LocY/BotInfo/Sensors and
//   writes their eight hex nibbles to the digit ports Dig7..Dig0.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     enable              level; gates the start of new sequences only
//     port_id, out_port   bus address and write data
//     in_port             read data from the responder
//     read_strobe         one-cycle read strobe
//     write_strobe        one-cycle write strobe
//     interrupt           level interrupt, held until acknowledged
//     interrupt_ack       one-cycle acknowledge
//     busy                high whenever the sequencer is not idle
//     seq_done            one-cycle pulse after the final digit write
//     frame_count         completed sequences, wrapping at 8 bits
module bot_port_master
  import bot_port_master_pkg::*;
#(
  parameter logic [7:0] PA_LOCX     = PA_LOCX_DEF,
  parameter logic [7:0] PA_LOCY     = PA_LOCY_DEF,
  parameter logic [7:0] PA_BOTINFO  = PA_BOTINFO_DEF,
  parameter logic [7:0] PA_SENSORS  = PA_SENSORS_DEF,
  parameter logic [7:0] PA_DIG_BASE = PA_DIG_BASE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  input  logic [7:0] in_port,
  output logic       read_strobe,
  output logic       write_strobe,
  input  logic       interrupt,
  output logic       interrupt_ack,
  output logic       busy,
  output logic       seq_done,
  output logic [7:0] frame_count
);

  localparam logic [2:0] RD_LAST = 3'(RD_COUNT - 1);
  localparam logic [2:0] WR_LAST = 3'(WR_COUNT - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cap_q [RD_COUNT];
  logic       ack_q, busy_q, seqDone_q;
  logic [7:0] frameCount_q;

  logic       xactStart, xactIsWrite, xactDone;
  logic [7:0] xactAddr, xactData, xactRdata;

  // Outputs are registered from the next state so each one lines up with
  // the cycle its state occupies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      seqDone_q    <= 1'b0;
      frameCount_q <= 8'h00;
      for (int i = 0; i < RD_COUNT; i++) cap_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ack_q     <= (state_d == ST_ACK);
      busy_q    <= (state_d != ST_IDLE);
      seqDone_q <= (state_d == ST_DONE);
      if (state_d == ST_DONE) frameCount_q <= frameCount_q + 8'd1;
      if (state_q == ST_RD_STROBE && xactDone) cap_q[idx_q[1:0]] <= xactRdata;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE:      if (enable && interrupt) state_d = ST_ACK;
      ST_ACK: begin
        state_d = ST_RD_SETUP;
        idx_d   = 3'd0;
      end
      ST_RD_SETUP:  state_d = ST_RD_STROBE;
      ST_RD_STROBE: begin
        if (idx_q == RD_LAST) begin
          state_d = ST_WR_SETUP;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_RD_SETUP;
          idx_d   = idx_q + 3'd1;
        end
      end
      ST_WR_SETUP:  state_d = ST_WR_STROBE;
      ST_WR_STROBE: begin
        if (idx_q == WR_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WR_SETUP;
          idx_d   = idx_q + 3'd1;
        end
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // The engine is loaded on the edge that enters a setup state, so address
  // and data come from the next index. Write idx 0 is Dig7 (LocX high nibble),
  // hence the descending digit address and idx[2:1] register select.
  always_comb begin
    xactStart   = (state_d == ST_RD_SETUP) || (state_d == ST_WR_SETUP);
    xactIsWrite = (state_d == ST_WR_SETUP);
    xactAddr    = 8'h00;
    xactData    = 8'h00;
    if (xactIsWrite) begin
      xactAddr = PA_DIG_BASE + {5'd0, WR_LAST - idx_d};
      xactData = {4'b0000, digitNibble(cap_q[idx_d[2:1]], idx_d[0])};
    end else begin
      case (idx_d[1:0])
        2'd0:    xactAddr = PA_LOCX;
        2'd1:    xactAddr = PA_LOCY;
        2'd2:    xactAddr = PA_BOTINFO;
        default: xactAddr = PA_SENSORS;
      endcase
    end
  end

  port_xact u_xact (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (xactStart),
    .isWrite_i     (xactIsWrite),
    .addr_i        (xactAddr),
    .data_i        (xactData),
    .inPort_i      (in_port),
    .portId_o      (port_id),
    .outPort_o     (out_port),
    .readStrobe_o  (read_strobe),
    .writeStrobe_o (write_strobe),
    .rdata_o       (xactRdata),
    .done_o        (xactDone)
  );

  assign interrupt_ack = ack_q;
  assign busy          = busy_q;
  assign seq_done      = seqDone_q;
  assign frame_count   = frameCount_q;

endmodule

// File: tb/tb_bot_port_master.sv
// tb_bot_port_master
//   Self-checking bench for bot_port_master. A responder model serves the four
//   bot registers only on read-strobe cycles (random data otherwise) and drops
//   the interrupt after it is acknowledged. Each sequence is compared cycle by
//   cycle against a reference built from the transaction list.
module tb_bot_port_master;

  localparam logic [7:0] ADDR_LOCX = 8'h0A;
  localparam logic [7:0] ADDR_DIG7 = 8'h17;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic       interrupt = 1'b0;
  logic [7:0] in_port;
  logic [7:0] port_id, out_port, frame_count;
  logic       read_strobe, write_strobe, interrupt_ack, busy, seq_done;

  logic [7:0] respVals [4];
  logic [7:0] garbage = 8'h00;
  int         raiseCount = 0;
  int         raisesServed = 0;
  int         checks = 0;
  int         passes = 0;
  logic [7:0] expFrame = 8'h00;

  always #5 clk = ~clk;

  bot_port_master dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .port_id       (port_id),
    .out_port      (out_port),
    .in_port       (in_port),
    .read_strobe   (read_strobe),
    .write_strobe  (write_strobe),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .busy          (busy),
    .seq_done      (seq_done),
    .frame_count   (frame_count)
  );

  // Responder read path: real register data only while read_strobe is high
  always_comb begin
    in_port = garbage;
    if (read_strobe && port_id >= ADDR_LOCX && port_id <= ADDR_LOCX + 8'd3)
      in_port = respVals[2'(port_id - ADDR_LOCX)];
  end

  // Responder interrupt source: raise on request, drop once acknowledged
  always @(negedge clk) begin
    garbage = 8'($urandom);
    if (interrupt_ack) begin
      interrupt = 1'b0;
    end else if (raiseCount > raisesServed) begin
      interrupt = 1'b1;
      raisesServed++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  function automatic logic [31:0] outWord();
    return {11'd0, interrupt_ack, seq_done, read_strobe, write_strobe, busy, port_id, out_port};
  endfunction

  // Reference for relative cycle r of a sequence (r=1 is the acknowledge
  // cycle): 4 reads of two cycles each, 8 digit writes of two cycles each,
  // then the done cycle.
  function automatic logic [31:0] expWord(input int r, input logic [31:0] vals);
    logic       ack = 1'b0, dn = 1'b0, rd = 1'b0, wr = 1'b0, bz = 1'b1;
    logic [7:0] p = 8'h00, o = 8'h00, b;
    int         k;
    if (r == 1) begin
      ack = 1'b1;
    end else if (r <= 9) begin
      k  = (r - 2) / 2;
      rd = ((r - 2) % 2) == 1;
      p  = ADDR_LOCX + 8'(k);
    end else if (r <= 25) begin
      k  = (r - 10) / 2;
      wr = ((r - 10) % 2) == 1;
      p  = ADDR_DIG7 - 8'(k);
      b  = vals[(k / 2) * 8 +: 8];
      o  = {4'h0, ((k % 2) == 0) ? b[7:4] : b[3:0]};
    end else begin
      dn = 1'b1;
    end
    return {11'd0, ack, dn, rd, wr, bz, p, o};
  endfunction

  task automatic quietCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("quiet", {27'd0, busy, read_strobe, write_strobe, interrupt_ack, seq_done}, 32'd0);
    end
  endtask

  // Waits (bounded) for the acknowledge, then checks every cycle of the
  // sequence. Optional hooks at relative cycles: re-raise the interrupt,
  // drop enable, or assert reset mid-cycle and abandon the sequence.
  task automatic applyStimulus(input logic [31:0] vals, input int maxWait,
                               input int raiseAt, input int dropEnAt, input int resetAt);
    logic        found = 1'b0;
    logic [31:0] obs;
    for (int i = 0; i < 4; i++) respVals[i] = vals[i*8 +: 8];
    for (int i = 0; i < maxWait; i++) begin
      @(negedge clk);
      if (interrupt_ack) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("ackSeen", 32'(found), 32'd1);
    if (!found) return;
    for (int r = 1; r <= 26; r++) begin
      if (r > 1) @(negedge clk);
      obs = outWord();
      if (r == 1 || r == 26) obs[15:0] = 16'h0000;
      checkOutput($sformatf("cycle%0d", r), obs, expWord(r, vals));
      if (r == raiseAt) raiseCount++;
      if (r == dropEnAt) enable = 1'b0;
      if (r == resetAt) begin
        rst = 1'b1;
        #1;
        checkOutput("rstMidOutputs", outWord(), 32'd0);
        checkOutput("rstMidFrame", 32'(frame_count), 32'd0);
        expFrame = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    expFrame = expFrame + 8'd1;
    checkOutput("frameCount", 32'(frame_count), 32'(expFrame));
    checkOutput("idleBusy", 32'(busy), 32'd0);
  endtask

  initial begin
    int sawActivity;
    for (int i = 0; i < 4; i++) respVals[i] = 8'h00;

    // Asynchronous reset asserted mid-cycle
    #13 rst = 1'b1;
    #1;
    checkOutput("rstInitOutputs", outWord(), 32'd0);
    checkOutput("rstInitFrame", 32'(frame_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quietCycles(100);

    // Basic sequence with known register values
    $display("[TB] basic sequence");
    raiseCount++;
    applyStimulus(32'hC4215F3A, 6, 0, 0, 0);

    // Enable gating: interrupt pending but enable low
    $display("[TB] enable gating");
    enable = 1'b0;
    raiseCount++;
    sawActivity = 0;
    repeat (50) begin
      @(negedge clk);
      if (interrupt_ack || busy) sawActivity++;
    end
    checkOutput("gateIdle", 32'(sawActivity), 32'd0);
    enable = 1'b1;
    applyStimulus($urandom, 1, 0, 0, 0);

    // Back-to-back: re-raise during the first, drop enable during the second
    $display("[TB] back-to-back");
    raiseCount++;
    applyStimulus($urandom, 6, 10, 0, 0);
    applyStimulus($urandom, 1, 0, 12, 0);
    enable = 1'b1;

    // Reset during the strobe cycle of the Dig4 write
    $display("[TB] reset mid-sequence");
    raiseCount++;
    applyStimulus($urandom, 6, 0, 0, 17);
    quietCycles(100);

    // 256 random sequences: frame counter wraps back to zero
    $display("[TB] wrap run");
    for (int s = 0; s < 256; s++) begin
      raiseCount++;
      applyStimulus($urandom, 6, 0, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    checkOutput("frameWrap", 32'(frame_count), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
